// File: rtl/dec_seq_strobe.sv
// dec_seq_strobe: registered one-of-2^AW select decoder with a direct/scan strobe sequencer.
// Optional build macro DEC_SEQ_ACTIVE_LOW_EN makes z active-low (one-cold, idle all ones).
module dec_seq_strobe #(
    parameter int AW   = 3,
    parameter int HOLD = 1
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic               en,
    input  logic               start,
    input  logic               mode,
    input  logic [AW-1:0]      a,
    output logic [2**AW-1:0]   z,
    output logic               busy,
    output logic               done
);
    localparam int              NZ         = 2**AW;
    localparam logic [7:0]      CNT_RELOAD = 8'(HOLD - 1);
    localparam logic [AW-1:0]   ADDR_TOP   = {AW{1'b1}};
`ifdef DEC_SEQ_ACTIVE_LOW_EN
    localparam logic [NZ-1:0]   Z_OFF      = {NZ{1'b1}};
`else
    localparam logic [NZ-1:0]   Z_OFF      = {NZ{1'b0}};
`endif

    typedef enum logic {IDLE = 1'b0, ASSERT = 1'b1} state_t;

    // Decoded select for one address, already in the output polarity.
    function automatic logic [NZ-1:0] sel(input logic [AW-1:0] ad);
        logic [NZ-1:0] v;
        v     = {NZ{1'b0}};
        v[ad] = 1'b1;
        return v ^ Z_OFF;
    endfunction

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            mode_q, mode_d;
    logic [NZ-1:0]   z_q, z_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [AW-1:0]   addr_inc;

    assign addr_inc = addr_q + AW'(1);

    // Next-state and next-output logic; z is computed one cycle ahead so it comes straight off flops.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        z_d     = z_q;
        busy_d  = busy_q;
        done_d  = done_q;
        if (en) begin
            done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_d  = a;
                        mode_d  = mode;
                        cnt_d   = CNT_RELOAD;
                        state_d = ASSERT;
                        z_d     = sel(a);
                        busy_d  = 1'b1;
                    end else begin
                        z_d    = Z_OFF;
                        busy_d = 1'b0;
                    end
                end
                ASSERT: begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else if (!mode_q || (addr_q == ADDR_TOP)) begin
                        state_d = IDLE;
                        z_d     = Z_OFF;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Scan step: move to the next address with no idle gap.
                        addr_d = addr_inc;
                        cnt_d  = CNT_RELOAD;
                        z_d    = sel(addr_inc);
                    end
                end
                default: begin
                    state_d = IDLE;
                    z_d     = Z_OFF;
                    busy_d  = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= {AW{1'b0}};
            cnt_q   <= 8'd0;
            mode_q  <= 1'b0;
            z_q     <= Z_OFF;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            z_q     <= z_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign z    = z_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_dec_seq_strobe.sv
// Scoreboard bench for dec_seq_strobe: three instances (HOLD=1,2,3) share stimulus and are
// checked every cycle against a sequence-list reference model.
module tb_dec_seq_strobe;

    typedef struct packed {
        logic [7:0] z;
        logic       busy;
        logic       done;
    } out_t;
    typedef out_t [2:0] trio_t;

    logic       sys_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       en      = 1'b0;
    logic       start   = 1'b0;
    logic       mode    = 1'b0;
    logic [2:0] a       = 3'd0;

    logic [7:0] z0, z1, z2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;

    dec_seq_strobe #(.AW(3), .HOLD(1)) u_h1 (
        .sys_clk(sys_clk), .reset(reset), .en(en), .start(start), .mode(mode), .a(a),
        .z(z0), .busy(busy0), .done(done0)
    );
    dec_seq_strobe #(.AW(3), .HOLD(2)) u_h2 (
        .sys_clk(sys_clk), .reset(reset), .en(en), .start(start), .mode(mode), .a(a),
        .z(z1), .busy(busy1), .done(done1)
    );
    dec_seq_strobe #(.AW(3), .HOLD(3)) u_h3 (
        .sys_clk(sys_clk), .reset(reset), .en(en), .start(start), .mode(mode), .a(a),
        .z(z2), .busy(busy2), .done(done2)
    );

    always #5 sys_clk = ~sys_clk;

    int    errors = 0;
    int    checks = 0;
    trio_t sb[$];
    trio_t act;
    trio_t exp_now;

    // Reference model: on an accepted start the whole per-cycle output list is laid out up front.
    out_t  plan [3][0:63];
    int    plen [3];
    int    pidx [3];
    out_t  cur  [3];

    assign act = {{z2, busy2, done2}, {z1, busy1, done1}, {z0, busy0, done0}};

    task automatic model_edge();
        trio_t t;
        int    n;
        int    last;
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                plen[k] = 0;
                pidx[k] = 0;
                cur[k]  = '0;
            end else if (en) begin
                if (pidx[k] < plen[k]) begin
                    cur[k]  = plan[k][pidx[k]];
                    pidx[k] = pidx[k] + 1;
                end else if (start) begin
                    n    = 0;
                    last = mode ? 7 : int'(a);
                    for (int ad = int'(a); ad <= last; ad++) begin
                        for (int h = 0; h < k + 1; h++) begin
                            plan[k][n].z    = 8'd1 << ad;
                            plan[k][n].busy = 1'b1;
                            plan[k][n].done = 1'b0;
                            n = n + 1;
                        end
                    end
                    plan[k][n].z    = 8'd0;
                    plan[k][n].busy = 1'b0;
                    plan[k][n].done = 1'b1;
                    plen[k] = n + 1;
                    cur[k]  = plan[k][0];
                    pidx[k] = 1;
                end else begin
                    cur[k] = '0;
                end
            end
            t[k] = cur[k];
        end
        sb.push_back(t);
    endtask

    task automatic chk(input string name, input int k, input logic [7:0] got, input logic [7:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s hold=%0d: got %h, expected %h at %0t", name, k + 1, got, want, $time);
        end
    endtask

    // Monitor: compare what the DUTs present after each edge against the queued expectation.
    always @(negedge sys_clk) begin
        if (sb.size() > 0) begin
            exp_now = sb.pop_front();
            for (int k = 0; k < 3; k++) begin
`ifdef DEC_SEQ_ACTIVE_LOW_EN
                chk("z", k, act[k].z, ~exp_now[k].z);
`else
                chk("z", k, act[k].z, exp_now[k].z);
`endif
                chk("busy", k, {7'd0, act[k].busy}, {7'd0, exp_now[k].busy});
                chk("done", k, {7'd0, act[k].done}, {7'd0, exp_now[k].done});
            end
        end
    end

    task automatic cycle(input logic r, input logic e, input logic s, input logic m, input logic [2:0] aa);
        @(negedge sys_clk);
        #1;
        reset = r;
        en    = e;
        start = s;
        mode  = m;
        a     = aa;
        model_edge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    endtask

    initial begin
        // Reset, with a start that reset must override.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 3'd3);
        // Direct a=5.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd5);
        idle(5);
        // Direct a=0; starts while busy must be ignored.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'd7);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd4);
        idle(4);
        // Scan from 5, no wrap.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'd5);
        idle(12);
        // Scan from 6 with a 4-cycle pause, then back-to-back start in the done cycle.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'd6);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 3'd2);
        idle(2);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd1);
        idle(6);
        // Mid-sequence reset during a scan from 0, then a fresh start.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'd0);
        idle(2);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd3);
        idle(5);
        // Scan starting at the top address acts as direct.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'd7);
        idle(5);
        // Done pulse frozen by en=0.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd2);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        idle(5);
        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 8,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                  3'($urandom_range(0, 7)));
        end
        idle(3);
        @(negedge sys_clk);
        #2;
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
